div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_div_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one external divider among NUM_REQ requesters.
// Optional feature macro DIV_ARBITER_DIVZERO_EN: answer zero denominators locally with divz_err.
module div_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_n,
   input  logic [NUM_REQ*WIDTH-1:0] req_d,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     divz_err,
   output logic                     busy,
   output logic [WIDTH-1:0]         div_n,
   output logic [WIDTH-1:0]         div_d,
   output logic                     div_in_valid,
   input  logic                     div_out_valid,
   input  logic [WIDTH-1:0]         div_out
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   last_owner;
   logic [OW-1:0]   grant_idx;
   logic            grant_found;
   logic            grant_en;
   logic            resp_en;
   logic [WIDTH-1:0] sel_n;
   logic [WIDTH-1:0] sel_d;

`ifdef DIV_ARBITER_DIVZERO_EN
   logic            zero_d;
   logic            divz_pending;
   logic            divz_resp_en;
`endif

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // Search upward from the requester after the last one served, wrapping around.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_owner) + i) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = OW'(idx);
         end
      end
   end

   assign sel_n = req_n[int'(grant_idx)*WIDTH +: WIDTH];
   assign sel_d = req_d[int'(grant_idx)*WIDTH +: WIDTH];
   assign busy  = (state != IDLE);

`ifdef DIV_ARBITER_DIVZERO_EN
   assign zero_d       = (sel_d == '0);
   assign divz_resp_en = (state == RESP) && divz_pending;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_en   = 1'b0;
      resp_en    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               grant_en   = 1'b1;
               state_next = WAIT;
`ifdef DIV_ARBITER_DIVZERO_EN
               if (zero_d) begin
                  state_next = RESP;
               end
`endif
            end
         end
         WAIT: begin
            if (div_out_valid) begin
               resp_en    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Strobes clear every cycle; operands stay latched until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready    <= '0;
         resp_valid   <= '0;
         resp_data    <= '0;
         div_in_valid <= 1'b0;
         div_n        <= '0;
         div_d        <= '0;
         owner        <= '0;
         last_owner   <= OW'(NUM_REQ - 1);
`ifdef DIV_ARBITER_DIVZERO_EN
         divz_err     <= 1'b0;
         divz_pending <= 1'b0;
`endif
      end else begin
         req_ready    <= '0;
         resp_valid   <= '0;
         div_in_valid <= 1'b0;
`ifdef DIV_ARBITER_DIVZERO_EN
         divz_err     <= 1'b0;
`endif
         if (grant_en) begin
            owner     <= grant_idx;
            div_n     <= sel_n;
            div_d     <= sel_d;
            req_ready <= onehot(grant_idx);
`ifdef DIV_ARBITER_DIVZERO_EN
            div_in_valid <= !zero_d;
            divz_pending <= zero_d;
`else
            div_in_valid <= 1'b1;
`endif
         end
         if (resp_en) begin
            resp_data  <= div_out;
            resp_valid <= onehot(owner);
            last_owner <= owner;
         end
`ifdef DIV_ARBITER_DIVZERO_EN
         // Zero denominator: answer with the largest positive value instead of using the divider.
         if (divz_resp_en) begin
            resp_data    <= {1'b0, {(WIDTH-1){1'b1}}};
            resp_valid   <= onehot(owner);
            divz_err     <= 1'b1;
            last_owner   <= owner;
            divz_pending <= 1'b0;
         end
`endif
      end
   end

`ifndef DIV_ARBITER_DIVZERO_EN
   assign divz_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed testbench for div_arbiter: the bench plays the divider (Q16.16 quotient, 17-cycle latency)
// and checks grant order, operand latching, response routing, reset abandonment and spurious strobes.
module tb_div_arbiter;

   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 4;
   localparam int LAT     = 17;

   logic                     clk;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_n;
   logic [NUM_REQ*WIDTH-1:0] req_d;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [WIDTH-1:0]         resp_data;
   logic                     divz_err;
   logic                     busy;
   logic [WIDTH-1:0]         div_n;
   logic [WIDTH-1:0]         div_d;
   logic                     div_in_valid;
   logic                     div_out_valid;
   logic [WIDTH-1:0]         div_out;

   int vectors;
   int miscompares;

   div_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_n         (req_n),
      .req_d         (req_d),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .divz_err      (divz_err),
      .busy          (busy),
      .div_n         (div_n),
      .div_d         (div_d),
      .div_in_valid  (div_in_valid),
      .div_out_valid (div_out_valid),
      .div_out       (div_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference Q16.16 quotient; all-ones stands in for a zero denominator.
   function automatic logic [31:0] qmodel(input logic [31:0] n, input logic [31:0] d);
      logic [63:0] num;
      if (d == 32'h0) return 32'hFFFF_FFFF;
      num = {16'h0, n, 16'h0};
      return 32'(num / {32'h0, d});
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
      req_valid = valid;
   endtask

   task automatic setOperands(input int slot, input logic [31:0] n, input logic [31:0] d);
      req_n[slot*WIDTH +: WIDTH] = n;
      req_d[slot*WIDTH +: WIDTH] = d;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Waits for a grant, plays the divider, and checks the routed response; returns in the IDLE cycle.
   task automatic serveOne(input string tag, input int g, input logic [31:0] n, input logic [31:0] d,
                           output int waited);
      logic [31:0] q;
      q      = qmodel(n, d);
      waited = 0;
      while (req_ready == '0 && waited < 60) begin
         nextCycle();
         waited++;
      end
      if (req_ready == '0) begin
         checkOutput({tag, "_grant_timeout"}, 64'd0, 64'd1);
         return;
      end
      checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(1) << g);
      checkOutput({tag, "_div_in_valid"}, 64'(div_in_valid), 64'd1);
      checkOutput({tag, "_div_n"}, 64'(div_n), 64'(n));
      checkOutput({tag, "_div_d"}, 64'(div_d), 64'(d));
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      nextCycle();
      checkOutput({tag, "_strobes_pulse"}, 64'({req_ready, div_in_valid}), 64'd0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      checkOutput({tag, "_div_n_hold"}, 64'(div_n), 64'(n));
      checkOutput({tag, "_no_early_resp"}, 64'(resp_valid), 64'd0);
      div_out_valid = 1'b1;
      div_out       = qmodel(div_n, div_d);
      nextCycle();
      div_out_valid = 1'b0;
      div_out       = '0;
      checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(1) << g);
      checkOutput({tag, "_resp_data"}, 64'(resp_data), 64'(q));
      checkOutput({tag, "_divz_err"}, 64'(divz_err), 64'd0);
      nextCycle();
      checkOutput({tag, "_resp_pulse"}, 64'({resp_valid, busy}), 64'd0);
   endtask

`ifdef DIV_ARBITER_DIVZERO_EN
   task automatic serveDivz(input string tag, input int g);
      int waited;
      waited = 0;
      while (req_ready == '0 && waited < 60) begin
         nextCycle();
         waited++;
      end
      if (req_ready == '0) begin
         checkOutput({tag, "_grant_timeout"}, 64'd0, 64'd1);
         return;
      end
      checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(1) << g);
      checkOutput({tag, "_no_div_in_valid"}, 64'(div_in_valid), 64'd0);
      nextCycle();
      checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(1) << g);
      checkOutput({tag, "_resp_data"}, 64'(resp_data), 64'h7FFF_FFFF);
      checkOutput({tag, "_divz_err"}, 64'(divz_err), 64'd1);
   endtask
`endif

   initial begin
      int waited;
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      req_valid     = '0;
      req_n         = '0;
      req_d         = '0;
      div_out_valid = 1'b0;
      div_out       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         setOperands(i, 32'((i + 1) * 32'h0001_0000 + i * 32'h1234), 32'((i + 1) * 32'h0000_8000));
      end

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
      checkOutput("rst_div_ops", 64'({div_n, div_d}), 64'd0);
      checkOutput("rst_flags", 64'({busy, div_in_valid, divz_err}), 64'd0);
      rst = 1'b0;

      // Two active requesters: 1, 2, 1
      applyStimulus(4'b0110);
      serveOne("rr0110_a", 1, 32'h0002_1234, 32'h0001_0000, waited);
      serveOne("rr0110_b", 2, 32'h0003_2468, 32'h0001_8000, waited);
      serveOne("rr0110_c", 1, 32'h0002_1234, 32'h0001_0000, waited);
      applyStimulus(4'b0000);
      nextCycle();

      // All requesters: 0, 1, 2, 3, 0
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'b1111);
      serveOne("rr1111_0", 0, 32'h0001_0000, 32'h0000_8000, waited);
      serveOne("rr1111_1", 1, 32'h0002_1234, 32'h0001_0000, waited);
      serveOne("rr1111_2", 2, 32'h0003_2468, 32'h0001_8000, waited);
      serveOne("rr1111_3", 3, 32'h0004_369C, 32'h0002_0000, waited);
      serveOne("rr1111_4", 0, 32'h0001_0000, 32'h0000_8000, waited);
      applyStimulus(4'b0000);
      nextCycle();

      // Single requester 2: 1.5 result, then immediate regrant
      setOperands(2, 32'h0003_0000, 32'h0002_0000);
      applyStimulus(4'b0100);
      serveOne("single_a", 2, 32'h0003_0000, 32'h0002_0000, waited);
      checkOutput("q_1p5_literal", 64'(qmodel(32'h0003_0000, 32'h0002_0000)), 64'h0001_8000);
      serveOne("single_b", 2, 32'h0003_0000, 32'h0002_0000, waited);
      checkOutput("single_regrant_gap", 64'(waited), 64'd1);
      applyStimulus(4'b0000);

      // Zero denominator from requester 1 (last owner 2 -> search 3,0,1)
      setOperands(1, 32'h0005_0000, 32'h0000_0000);
      applyStimulus(4'b0010);
`ifdef DIV_ARBITER_DIVZERO_EN
      serveDivz("divz", 1);
`else
      serveOne("divz_pass", 1, 32'h0005_0000, 32'h0000_0000, waited);
`endif
      applyStimulus(4'b0000);
      nextCycle();

      // Reset while waiting on the divider abandons the operation
      applyStimulus(4'b0100);
      waited = 0;
      while (req_ready == '0 && waited < 60) begin
         nextCycle();
         waited++;
      end
      checkOutput("abort_grant", 64'(req_ready), 64'b0100);
      repeat (3) nextCycle();
      rst = 1'b1;
      applyStimulus(4'b0000);
      nextCycle();
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_div_n", 64'(div_n), 64'd0);
      repeat (3) nextCycle();
      div_out_valid = 1'b1;
      div_out       = 32'h1234_5678;
      nextCycle();
      div_out_valid = 1'b0;
      div_out       = '0;
      checkOutput("abort_late_resp", 64'({resp_valid, busy}), 64'd0);
      checkOutput("abort_resp_data", 64'(resp_data), 64'd0);
      applyStimulus(4'b1111);
      serveOne("after_abort", 0, 32'h0001_0000, 32'h0000_8000, waited);
      applyStimulus(4'b0000);

      // Spurious divider strobe in IDLE
      nextCycle();
      div_out_valid = 1'b1;
      div_out       = 32'hDEAD_BEEF;
      nextCycle();
      div_out_valid = 1'b0;
      div_out       = '0;
      checkOutput("spur_resp_data", 64'(resp_data), 64'h0002_0000);
      checkOutput("spur_strobes", 64'({resp_valid, req_ready, div_in_valid, divz_err, busy}), 64'd0);
      nextCycle();
      checkOutput("spur_still_idle", 64'({resp_valid, busy}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
